// File: rtl/arb_types.sv
// Shared types for the CPU-side memory arbiter: FSM states and the latched request.
package arb_types;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_MBE_W  = ARB_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    D_BUSY,
    I_BUSY,
    D_RESP,
    I_RESP
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_MBE_W-1:0]  mbe;
    logic                  is_write;
    logic                  is_data;
  } arb_req_t;

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter: advances by one on each inc pulse.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     count <= '0;
    else if (inc) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one backing-memory port between instruction fetch and data load/store.
// Data wins ties; ADDR_W/DATA_W must not exceed the widths in arb_types.
//   state  | meaning
//   IDLE   | sample CPU requests, data first
//   D_BUSY | data op on memory, wait mem_resp
//   I_BUSY | fetch on memory, wait mem_resp
//   D_RESP | one-cycle data_mem_resp
//   I_RESP | one-cycle instr_mem_resp
module cpu_mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_read,
  input  logic [ADDR_W-1:0]   instr_mem_address,
  output logic                instr_mem_resp,
  output logic [DATA_W-1:0]   instr_mem_rdata,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W/8-1:0] data_mbe,
  input  logic [ADDR_W-1:0]   data_mem_address,
  input  logic [DATA_W-1:0]   data_mem_wdata,
  output logic                data_mem_resp,
  output logic [DATA_W-1:0]   data_mem_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mbe,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    instr_served,
  output logic [CNT_W-1:0]    data_served,
  output logic                arb_err
);

  arb_state_t state_q, state_d;
  arb_req_t   req_q;
  logic       busy;
  logic       data_req;

  assign data_req = data_read | data_write;
  assign busy     = (state_q == D_BUSY) || (state_q == I_BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (data_req)        state_d = D_BUSY;
        else if (instr_read) state_d = I_BUSY;
      end
      D_BUSY:  if (mem_resp) state_d = D_RESP;
      I_BUSY:  if (mem_resp) state_d = I_RESP;
      D_RESP:  state_d = IDLE;
      I_RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A simultaneous read+write is treated as a write; fetches and loads use full-word enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
    end else if (state_q == IDLE) begin
      if (data_req) begin
        req_q.addr     <= ARB_ADDR_W'(data_mem_address);
        req_q.wdata    <= ARB_DATA_W'(data_mem_wdata);
        req_q.mbe      <= data_write ? ARB_MBE_W'(data_mbe) : '1;
        req_q.is_write <= data_write;
        req_q.is_data  <= 1'b1;
      end else if (instr_read) begin
        req_q.addr     <= ARB_ADDR_W'(instr_mem_address);
        req_q.wdata    <= '0;
        req_q.mbe      <= '1;
        req_q.is_write <= 1'b0;
        req_q.is_data  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_mem_rdata <= '0;
      data_mem_rdata  <= '0;
    end else if (busy && mem_resp) begin
      if (req_q.is_data) data_mem_rdata  <= mem_rdata;
      else               instr_mem_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_err <= 1'b0;
    end else if ((mem_resp && !busy) || (state_q == IDLE && data_read && data_write)) begin
      arb_err <= 1'b1;
    end
  end

  assign mem_read       = busy && !req_q.is_write;
  assign mem_write      = busy && req_q.is_write;
  assign mem_address    = ADDR_W'(req_q.addr);
  assign mem_wdata      = DATA_W'(req_q.wdata);
  assign mem_mbe        = (DATA_W/8)'(req_q.mbe);
  assign instr_mem_resp = (state_q == I_RESP);
  assign data_mem_resp  = (state_q == D_RESP);

  perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_mem_resp),
    .count (instr_served)
  );

  perf_counter #(.CNT_W(CNT_W)) u_data_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (data_mem_resp),
    .count (data_served)
  );

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter (4-bit counters to exercise wrap).
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_read = 1'b0;
  logic [31:0] instr_mem_address = '0;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [3:0]  data_mbe = '0;
  logic [31:0] data_mem_address = '0;
  logic [31:0] data_mem_wdata = '0;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mbe;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  instr_served;
  logic [3:0]  data_served;
  logic        arb_err;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_read(instr_read), .instr_mem_address(instr_mem_address),
    .instr_mem_resp(instr_mem_resp), .instr_mem_rdata(instr_mem_rdata),
    .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
    .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
    .data_mem_resp(data_mem_resp), .data_mem_rdata(data_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_mbe(mem_mbe), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .instr_served(instr_served), .data_served(data_served), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int i_cnt = 0;
  int d_cnt = 0;

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    int          k;
    logic [31:0] rdata;
    bit          exp_rd;
    bit          exp_wr;
    logic [3:0]  exp_mbe;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " mem_read"}, mem_read, 0);
    chk({tag, " mem_write"}, mem_write, 0);
    chk({tag, " mem_address"}, mem_address, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " mem_mbe"}, mem_mbe, 0);
    chk({tag, " instr_mem_resp"}, instr_mem_resp, 0);
    chk({tag, " data_mem_resp"}, data_mem_resp, 0);
    chk({tag, " instr_mem_rdata"}, instr_mem_rdata, 0);
    chk({tag, " data_mem_rdata"}, data_mem_rdata, 0);
    chk({tag, " instr_served"}, instr_served, 0);
    chk({tag, " data_served"}, data_served, 0);
    chk({tag, " arb_err"}, arb_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    instr_read = 0; data_read = 0; data_write = 0; mem_resp = 0; mem_rdata = '0;
    i_cnt = 0; d_cnt = 0;
    tick();
    check_all_zero("reset");
    rst = 1'b1;
  endtask

  // Single isolated transaction: request driven now (cycle 0), mem_resp at cycle k.
  task automatic run_vec(input vec_t v);
    if (v.is_data) begin
      data_read = !v.wr; data_write = v.wr;
      data_mem_address = v.addr; data_mem_wdata = v.wdata; data_mbe = v.mbe;
    end else begin
      instr_read = 1; instr_mem_address = v.addr;
    end
    for (int c = 1; c <= v.k; c++) begin
      tick();
      chk("vec mem_read", mem_read, v.exp_rd);
      chk("vec mem_write", mem_write, v.exp_wr);
      chk("vec mem_address", mem_address, v.addr);
      chk("vec mem_mbe", mem_mbe, v.exp_mbe);
      if (v.wr) chk("vec mem_wdata", mem_wdata, v.wdata);
      chk("vec early resp", instr_mem_resp | data_mem_resp, 0);
      if (c == v.k) begin mem_resp = 1; mem_rdata = v.rdata; end
    end
    tick();
    mem_resp = 0; mem_rdata = '0;
    chk("vec instr_mem_resp", instr_mem_resp, !v.is_data);
    chk("vec data_mem_resp", data_mem_resp, v.is_data);
    chk("vec strobes in resp", mem_read | mem_write, 0);
    if (!v.is_data) chk("vec instr_mem_rdata", instr_mem_rdata, v.rdata);
    else if (!v.wr) chk("vec data_mem_rdata", data_mem_rdata, v.rdata);
    chk("vec instr_served pre", instr_served, i_cnt % 16);
    chk("vec data_served pre", data_served, d_cnt % 16);
    instr_read = 0; data_read = 0; data_write = 0;
    if (v.is_data) d_cnt++; else i_cnt++;
    tick();
    chk("vec resp dropped", instr_mem_resp | data_mem_resp, 0);
    chk("vec instr_served", instr_served, i_cnt % 16);
    chk("vec data_served", data_served, d_cnt % 16);
  endtask

  // random-phase state
  bit          ri, rd, rsp_i_exp, rsp_d_exp, start_exp, start_data, idle_now;
  bit          t_data, t_wr;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_mbe;
  int          lat_left;
  vec_t        fv;

  initial begin
    vecs[0] = '{0, 0, 32'h60,  32'h0,        4'h0, 3, 32'h0000_0013, 1, 0, 4'hF};
    vecs[1] = '{1, 1, 32'h100, 32'hDEADBEEF, 4'h3, 2, 32'h0,         0, 1, 4'h3};
    vecs[2] = '{1, 0, 32'h200, 32'h0,        4'h1, 1, 32'hCAFEF00D,  1, 0, 4'hF};
    vecs[3] = '{0, 0, 32'h64,  32'h0,        4'h0, 1, 32'h0010_0093, 1, 0, 4'hF};
    vecs[4] = '{1, 1, 32'h104, 32'h12345678, 4'hC, 4, 32'h0,         0, 1, 4'hC};

    do_reset();
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // simultaneous fetch and load: data first, fetch after D_RESP
    instr_read = 1; instr_mem_address = 32'h40;
    data_read = 1; data_mem_address = 32'h80;
    tick();
    chk("sim first mem_read", mem_read, 1);
    chk("sim first address", mem_address, 32'h80);
    mem_resp = 1; mem_rdata = 32'h1111_1111;
    tick();
    mem_resp = 0;
    chk("sim data_mem_resp", data_mem_resp, 1);
    chk("sim no instr resp", instr_mem_resp, 0);
    chk("sim data_mem_rdata", data_mem_rdata, 32'h1111_1111);
    chk("sim strobe off in resp", mem_read, 0);
    data_read = 0; d_cnt++;
    tick();
    chk("sim idle gap", mem_read, 0);
    tick();
    chk("sim second mem_read", mem_read, 1);
    chk("sim second address", mem_address, 32'h40);
    mem_resp = 1; mem_rdata = 32'h2222_2222;
    tick();
    mem_resp = 0;
    chk("sim instr_mem_resp", instr_mem_resp, 1);
    chk("sim no data resp", data_mem_resp, 0);
    chk("sim instr_mem_rdata", instr_mem_rdata, 32'h2222_2222);
    instr_read = 0; i_cnt++;
    tick();
    chk("sim instr_served", instr_served, i_cnt % 16);
    chk("sim data_served", data_served, d_cnt % 16);
    tick();
    chk("sim no reissue", mem_read | mem_write, 0);

    // randomized traffic against transaction-level expectations
    lat_left = -1; start_exp = 0; rsp_i_exp = 0; rsp_d_exp = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      ri = rsp_i_exp; rd = rsp_d_exp;
      rsp_i_exp = 0; rsp_d_exp = 0;
      chk("rnd instr_mem_resp", instr_mem_resp, ri);
      chk("rnd data_mem_resp", data_mem_resp, rd);
      chk("rnd instr_served", instr_served, i_cnt % 16);
      chk("rnd data_served", data_served, d_cnt % 16);
      chk("rnd arb_err", arb_err, 0);
      if (ri) begin
        chk("rnd instr_mem_rdata", instr_mem_rdata, mem_model(instr_mem_address));
        instr_read = 0; i_cnt++;
      end
      if (rd) begin
        if (!data_write) chk("rnd data_mem_rdata", data_mem_rdata, mem_model(data_mem_address));
        data_read = 0; data_write = 0; d_cnt++;
      end
      if (start_exp) begin
        t_data  = start_data;
        t_wr    = start_data && data_write;
        t_addr  = start_data ? data_mem_address : instr_mem_address;
        t_wdata = data_mem_wdata;
        t_mbe   = t_wr ? data_mbe : 4'hF;
        lat_left = $urandom_range(0, 3);
        start_exp = 0;
      end
      if (lat_left >= 0) begin
        chk("rnd mem_read", mem_read, !t_wr);
        chk("rnd mem_write", mem_write, t_wr);
        chk("rnd mem_address", mem_address, t_addr);
        chk("rnd mem_mbe", mem_mbe, t_mbe);
        if (t_wr) chk("rnd mem_wdata", mem_wdata, t_wdata);
      end else begin
        chk("rnd strobes idle", mem_read | mem_write, 0);
      end
      idle_now = (lat_left < 0) && !ri && !rd;
      mem_resp = 0;
      if (lat_left == 0) begin
        mem_resp  = 1;
        mem_rdata = t_wr ? $urandom : mem_model(t_addr);
        if (t_data) rsp_d_exp = 1; else rsp_i_exp = 1;
        lat_left = -1;
      end else if (lat_left > 0) begin
        lat_left--;
      end
      if (!instr_read && $urandom_range(0, 2) == 0) begin
        instr_read = 1;
        instr_mem_address = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_read && !data_write && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) data_write = 1; else data_read = 1;
        data_mem_address = $urandom;
        data_mem_wdata   = $urandom;
        data_mbe         = 4'($urandom);
      end
      if (idle_now && (instr_read || data_read || data_write)) begin
        start_exp  = 1;
        start_data = data_read || data_write;
      end
    end

    // asynchronous reset mid-D_BUSY, then a pending fetch after release
    do_reset();
    run_vec(vecs[1]);
    data_read = 1; data_mem_address = 32'h300;
    tick();
    chk("rstmid busy", mem_read, 1);
    tick();
    #3;
    rst = 0;
    data_read = 0;
    instr_read = 1; instr_mem_address = 32'h44;
    #1;
    check_all_zero("rstmid");
    i_cnt = 0; d_cnt = 0;
    tick();
    rst = 1;
    tick();
    chk("rstmid fetch mem_read", mem_read, 1);
    chk("rstmid fetch address", mem_address, 32'h44);
    chk("rstmid fetch mbe", mem_mbe, 4'hF);
    mem_resp = 1; mem_rdata = 32'h33;
    tick();
    mem_resp = 0;
    chk("rstmid instr_mem_resp", instr_mem_resp, 1);
    chk("rstmid instr_mem_rdata", instr_mem_rdata, 32'h33);
    instr_read = 0;
    tick();
    chk("rstmid instr_served", instr_served, 1);
    chk("rstmid data_served", data_served, 0);

    // stray mem_resp in IDLE, then read+write together
    chk("err clean", arb_err, 0);
    mem_resp = 1; mem_rdata = '0;
    tick();
    mem_resp = 0;
    chk("err stray resp", arb_err, 1);
    data_read = 1; data_write = 1;
    data_mem_address = 32'h180; data_mem_wdata = 32'hA5A5_A5A5; data_mbe = 4'h5;
    tick();
    chk("err rw mem_write", mem_write, 1);
    chk("err rw mem_read", mem_read, 0);
    chk("err rw mem_mbe", mem_mbe, 4'h5);
    chk("err rw mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_resp = 1;
    tick();
    mem_resp = 0;
    chk("err rw data_mem_resp", data_mem_resp, 1);
    data_read = 0; data_write = 0;
    repeat (3) tick();
    chk("err sticky", arb_err, 1);
    do_reset();

    // 17 fetches wrap the 4-bit counter to 1
    fv = vecs[3];
    for (int n = 0; n < 17; n++) begin
      fv.addr = 32'h1000 + 32'(n * 4);
      fv.rdata = 32'h0000_0013 + 32'(n);
      run_vec(fv);
    end
    chk("wrap instr_served", instr_served, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
